// File: rtl/rap_move_pkg.sv
// Shared move command definitions used by the SPI parser, the move buffer and the DDA FSM.
package rap_move_pkg;

  localparam int unsigned MOVE_DURATION_BITS = 32;
  localparam int unsigned INCREMENT_BITS     = 64;

  typedef struct packed {
    logic [MOVE_DURATION_BITS-1:0] duration;
    logic                          dir;
    logic [INCREMENT_BITS-1:0]     increment;
    logic [INCREMENT_BITS-1:0]     incrementincrement;
  } move_cmd_t;

endpackage

// File: rtl/move_buffer_if.sv
// Write-side command handshake plus read-side slot view between the SPI layer, buffer and DDA FSM.
interface move_buffer_if #(
  parameter int unsigned buffer_bits        = 2,
  parameter int unsigned buffer_size        = 4,
  parameter int unsigned move_duration_bits = rap_move_pkg::MOVE_DURATION_BITS,
  parameter int unsigned increment_bits     = rap_move_pkg::INCREMENT_BITS
);
  logic                          wr_valid;
  logic                          wr_ready;
  logic [move_duration_bits-1:0] wr_duration;
  logic                          wr_dir;
  logic [increment_bits-1:0]     wr_increment;
  logic [increment_bits-1:0]     wr_incrementincrement;
  logic [buffer_bits-1:0]        moveind;
  logic                          move_done;
  logic [buffer_size-1:0]        stepready;
  logic [move_duration_bits-1:0] move_duration;
  logic                          move_dir;
  logic [increment_bits-1:0]     move_increment;
  logic [increment_bits-1:0]     move_incrementincrement;
  logic [buffer_bits:0]          occupancy;
  logic                          empty;
  logic                          err_underflow;

  modport master (
    output wr_valid, wr_duration, wr_dir, wr_increment, wr_incrementincrement, moveind, move_done,
    input  wr_ready, stepready, move_duration, move_dir, move_increment, move_incrementincrement,
    input  occupancy, empty, err_underflow
  );

  modport slave (
    input  wr_valid, wr_duration, wr_dir, wr_increment, wr_incrementincrement, moveind, move_done,
    output wr_ready, stepready, move_duration, move_dir, move_increment, move_incrementincrement,
    output occupancy, empty, err_underflow
  );
endinterface

// File: rtl/toggle_edge_detect.sv
// Turns a level-toggle completion signal into a single-cycle pulse.
module toggle_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic i_toggle,
  output logic o_pulse
);
  logic r_toggle_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_toggle_q <= 1'b0;
    else       r_toggle_q <= i_toggle;
  end

  assign o_pulse = i_toggle ^ r_toggle_q;
endmodule

// File: rtl/move_buffer.sv
// Ring buffer of pending moves feeding the DDA move FSM; tracks occupancy from the move_done toggle.
module move_buffer
  import rap_move_pkg::*;
#(
  parameter int unsigned buffer_bits = 2,
  parameter int unsigned buffer_size = 4
) (
  input logic          clk,
  input logic          reset,
  move_buffer_if.slave bus
);
  localparam logic [buffer_bits:0]   OccFull = buffer_size[buffer_bits:0];
  localparam logic [buffer_bits:0]   OccOne  = 1;
  localparam logic [buffer_bits-1:0] PtrOne  = 1;

  move_cmd_t              r_slots [buffer_size];
  logic [buffer_bits-1:0] r_wr_ptr, w_wr_ptr_d;
  logic [buffer_bits:0]   r_occupancy, w_occupancy_d;
  logic [buffer_size-1:0] r_stepready, w_stepready_d;
  logic                   r_err_underflow, w_err_underflow_d;
  logic                   w_accept, w_done_evt;
  move_cmd_t              w_wr_cmd, w_rd_cmd;

  toggle_edge_detect u_done_edge (
    .clk      (clk),
    .reset    (reset),
    .i_toggle (bus.move_done),
    .o_pulse  (w_done_evt)
  );

  assign bus.wr_ready = (r_occupancy != OccFull);
  assign w_accept     = bus.wr_valid & bus.wr_ready;

  always_comb begin
    w_wr_cmd                    = '0;
    w_wr_cmd.duration           = bus.wr_duration;
    w_wr_cmd.dir                = bus.wr_dir;
    w_wr_cmd.increment          = bus.wr_increment;
    w_wr_cmd.incrementincrement = bus.wr_incrementincrement;
  end

  // Storage is deliberately unreset so it stays a plain register array.
  always_ff @(posedge clk) begin
    if (w_accept) r_slots[r_wr_ptr] <= w_wr_cmd;
  end

  always_comb begin
    w_wr_ptr_d        = r_wr_ptr;
    w_occupancy_d     = r_occupancy;
    w_stepready_d     = r_stepready;
    w_err_underflow_d = r_err_underflow;
    if (w_accept) begin
      w_wr_ptr_d                = r_wr_ptr + PtrOne;
      w_stepready_d[r_wr_ptr]   = ~r_stepready[r_wr_ptr];
    end
    // A retire with nothing outstanding is an upstream protocol error; count stays at zero.
    if (w_done_evt && (r_occupancy == '0)) begin
      w_err_underflow_d = 1'b1;
    end
    if (w_accept && !w_done_evt) begin
      w_occupancy_d = r_occupancy + OccOne;
    end else if (!w_accept && w_done_evt && (r_occupancy != '0)) begin
      w_occupancy_d = r_occupancy - OccOne;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr        <= '0;
      r_occupancy     <= '0;
      r_stepready     <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      r_wr_ptr        <= w_wr_ptr_d;
      r_occupancy     <= w_occupancy_d;
      r_stepready     <= w_stepready_d;
      r_err_underflow <= w_err_underflow_d;
    end
  end

  assign w_rd_cmd                    = r_slots[bus.moveind];
  assign bus.move_duration           = w_rd_cmd.duration;
  assign bus.move_dir                = w_rd_cmd.dir;
  assign bus.move_increment          = w_rd_cmd.increment;
  assign bus.move_incrementincrement = w_rd_cmd.incrementincrement;
  assign bus.stepready               = r_stepready;
  assign bus.occupancy               = r_occupancy;
  assign bus.empty                   = (r_occupancy == '0);
  assign bus.err_underflow           = r_err_underflow;
endmodule

// File: tb/tb_move_buffer.sv
// Directed vector table, reset corner case and randomized run against a queue-level reference model.
module tb_move_buffer;
  import rap_move_pkg::*;

  localparam int unsigned BB = 2;
  localparam int unsigned BS = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  move_buffer_if #(
    .buffer_bits        (BB),
    .buffer_size        (BS),
    .move_duration_bits (MOVE_DURATION_BITS),
    .increment_bits     (INCREMENT_BITS)
  ) bus ();

  move_buffer #(
    .buffer_bits (BB),
    .buffer_size (BS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_rd(input string tag, input move_cmd_t e);
    chk({tag, " duration"}, 64'(bus.move_duration), 64'(e.duration));
    chk({tag, " dir"}, 64'(bus.move_dir), 64'(e.dir));
    chk({tag, " increment"}, bus.move_increment, e.increment);
    chk({tag, " incinc"}, bus.move_incrementincrement, e.incrementincrement);
  endtask

  task automatic drive(input bit v, input move_cmd_t c, input bit md, input logic [BB-1:0] mi);
    bus.wr_valid              = v;
    bus.wr_duration           = c.duration;
    bus.wr_dir                = c.dir;
    bus.wr_increment          = c.increment;
    bus.wr_incrementincrement = c.incrementincrement;
    bus.move_done             = md;
    bus.moveind               = mi;
  endtask

  // Reference model: slot contents, a count of outstanding moves and a write position.
  move_cmd_t   m_slot [BS];
  bit          m_written [BS];
  int          m_wr, m_occ;
  bit [BS-1:0] m_step;
  bit          m_err, m_prev;

  task automatic model_reset();
    m_wr = 0; m_occ = 0; m_step = '0; m_err = 0; m_prev = 0;
    for (int i = 0; i < BS; i++) m_written[i] = 0;
  endtask

  task automatic model_step(input bit v, input move_cmd_t c, input bit md);
    bit acc, done;
    acc = v && (m_occ < BS);
    done = md ^ m_prev;
    m_prev = md;
    if (done && m_occ == 0) m_err = 1;
    if (acc) begin
      m_slot[m_wr] = c;
      m_written[m_wr] = 1;
      m_step[m_wr] = ~m_step[m_wr];
      m_wr = (m_wr + 1) % BS;
    end
    if (acc && !done) m_occ++;
    else if (!acc && done && m_occ > 0) m_occ--;
  endtask

  task automatic check_model();
    chk("rnd occupancy", 64'(bus.occupancy), 64'(m_occ));
    chk("rnd stepready", 64'(bus.stepready), 64'(m_step));
    chk("rnd wr_ready", 64'(bus.wr_ready), 64'(m_occ != BS));
    chk("rnd empty", 64'(bus.empty), 64'(m_occ == 0));
    chk("rnd err_underflow", 64'(bus.err_underflow), 64'(m_err));
    if (m_written[bus.moveind]) chk_rd("rnd read", m_slot[bus.moveind]);
  endtask

  typedef struct {
    bit          v;
    move_cmd_t   c;
    bit          md;
    logic [BB-1:0] mi;
    bit          rd;
    move_cmd_t   e;
    int          occ;
    logic [BS-1:0] step;
    bit          rdy;
    bit          err;
  } vec_t;

  vec_t vt[14];
  move_cmd_t ca, cb, cc, cd, ce, cf, cg, ch, cz;

  initial begin
    ca = '{32'd5, 1'b1, 64'h100, 64'd2};
    cb = '{32'd7, 1'b0, 64'h200, 64'd3};
    cc = '{32'd9, 1'b1, 64'h300, 64'd4};
    cd = '{32'd11, 1'b0, 64'h400, 64'd5};
    ce = '{32'd13, 1'b1, 64'h500, 64'd6};
    cf = '{32'd15, 1'b0, 64'h600, 64'd7};
    cg = '{32'd17, 1'b1, 64'h700, 64'd8};
    ch = '{32'hdead_beef, 1'b1, 64'h0123_4567_89ab_cdef, 64'hffff_0000_ffff_0000};
    cz = '0;
    //         v  cmd md mi rd exp occ step     rdy err
    vt[0]  = '{1, ca, 0, 0, 1, ca, 1, 4'b0001, 1, 0};
    vt[1]  = '{1, cb, 0, 1, 1, cb, 2, 4'b0011, 1, 0};
    vt[2]  = '{1, cc, 0, 0, 0, cz, 3, 4'b0111, 1, 0};
    vt[3]  = '{1, cd, 0, 3, 1, cd, 4, 4'b1111, 0, 0};
    vt[4]  = '{1, ce, 0, 0, 1, ca, 4, 4'b1111, 0, 0};   // full: command held
    vt[5]  = '{1, ce, 1, 0, 1, ca, 3, 4'b1111, 1, 0};
    vt[6]  = '{1, ce, 1, 0, 1, ce, 4, 4'b1110, 0, 0};
    vt[7]  = '{0, cz, 0, 0, 0, cz, 3, 4'b1110, 1, 0};
    vt[8]  = '{0, cz, 1, 0, 0, cz, 2, 4'b1110, 1, 0};
    vt[9]  = '{1, cf, 0, 1, 1, cf, 2, 4'b1100, 1, 0};   // write + retire together
    vt[10] = '{0, cz, 1, 0, 0, cz, 1, 4'b1100, 1, 0};
    vt[11] = '{0, cz, 0, 0, 0, cz, 0, 4'b1100, 1, 0};
    vt[12] = '{0, cz, 1, 0, 0, cz, 0, 4'b1100, 1, 1};   // underflow
    vt[13] = '{1, cg, 1, 2, 1, cg, 1, 4'b1000, 1, 1};

    drive(0, cz, 0, '0);
    reset = 1'b1;
    #12;
    chk("reset occupancy", 64'(bus.occupancy), 64'd0);
    chk("reset stepready", 64'(bus.stepready), 64'd0);
    chk("reset empty", 64'(bus.empty), 64'd1);
    chk("reset wr_ready", 64'(bus.wr_ready), 64'd1);
    chk("reset err", 64'(bus.err_underflow), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].v, vt[i].c, vt[i].md, vt[i].mi);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d occupancy", i), 64'(bus.occupancy), 64'(vt[i].occ));
      chk($sformatf("vec%0d stepready", i), 64'(bus.stepready), 64'(vt[i].step));
      chk($sformatf("vec%0d wr_ready", i), 64'(bus.wr_ready), 64'(vt[i].rdy));
      chk($sformatf("vec%0d err", i), 64'(bus.err_underflow), 64'(vt[i].err));
      chk($sformatf("vec%0d empty", i), 64'(bus.empty), 64'(vt[i].occ == 0));
      if (vt[i].rd) chk_rd($sformatf("vec%0d read", i), vt[i].e);
    end

    // Two more writes bring occupancy to 3, then reset lands between clock edges.
    drive(1, ca, 1, '0);
    @(posedge clk);
    #1;
    drive(1, cb, 1, '0);
    @(posedge clk);
    #1;
    chk("pre-reset occupancy", 64'(bus.occupancy), 64'd3);
    drive(0, cz, 0, '0);
    reset = 1'b1;
    #1;
    chk("async reset occupancy", 64'(bus.occupancy), 64'd0);
    chk("async reset stepready", 64'(bus.stepready), 64'd0);
    chk("async reset err", 64'(bus.err_underflow), 64'd0);
    chk("async reset empty", 64'(bus.empty), 64'd1);
    chk("async reset wr_ready", 64'(bus.wr_ready), 64'd1);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    drive(1, ch, 0, '0);
    @(posedge clk);
    #1;
    drive(0, cz, 0, '0);
    chk("post-reset stepready", 64'(bus.stepready), 64'd1);
    chk("post-reset occupancy", 64'(bus.occupancy), 64'd1);
    chk_rd("post-reset slot0", ch);

    // Randomized run against the reference model.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      bit        v, md;
      move_cmd_t c;
      v = ($urandom_range(0, 9) < 6);
      c.duration           = $urandom;
      c.dir                = 1'($urandom_range(0, 1));
      c.increment          = {$urandom, $urandom};
      c.incrementincrement = {$urandom, $urandom};
      md = ($urandom_range(0, 9) < 4) ? ~m_prev : m_prev;
      drive(v, c, md, BB'($urandom_range(0, BS - 1)));
      model_step(v, c, md);
      @(posedge clk);
      #1;
      check_model();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
